hazard_scoreboard: RTL and testbench
====================================

# hazard_scoreboard

Parametrised operand-forwarding and load-use interlock unit for the in-order RISC-V pipeline, replacing the fixed two-source, fixed-depth forwarding logic at the decode/execute boundary. It tracks the destination register of every instruction in flight over `DEPTH` downstream slots. For each of `NUM_SRC` source operands it selects the youngest ready producer's result, or the register-file value. When the youngest producer is a load whose data is not yet available, it raises a stall and inserts a bubble.

## Interface
Parameters:
- `XLEN`, 32, datapath width.
- `REG_ADDR_W`, 5, register index width.
- `NUM_SRC`, 2, number of source operands checked per issue (1–3).
- `DEPTH`, 3, number of tracked in-flight slots. Slot 0 is the youngest, i.e. execute output; slot `DEPTH-1` is writeback.
- `LOAD_LAT`, 1, first slot index at which a load's result is valid (`1 ≤ LOAD_LAT < DEPTH`).

Ports:
- `clk_i`, in, 1: clock, rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `issue_valid_i`, in, 1: an instruction is presented at issue this cycle.
- `issue_rd_index_i`, in, `REG_ADDR_W`: destination of the issuing instruction. 0 means no write.
- `issue_is_load_i`, in, 1: the issuing instruction is a load.
- `issue_rs_index_i`, in, `NUM_SRC*REG_ADDR_W`: source indices; source k occupies bits `[k*REG_ADDR_W +: REG_ADDR_W]`.
- `issue_rs_value_i`, in, `NUM_SRC*XLEN`: register-file read values, packed the same way.
- `stage_result_i`, in, `DEPTH*XLEN`: result currently held by slot j, at `[j*XLEN +: XLEN]`.
- `flush_i`, in, 1: squash the issuing instruction (branch taken).
- `issue_rs_fwd_o`, out, `NUM_SRC*XLEN`: forwarded operand values.
- `stall_o`, out, 1: hold fetch/decode; a bubble enters slot 0.
- `stall_count_o`, out, 32: stall-cycle counter. Present only with the macro; see Configuration.

## Operation
Slot state consists of `valid`, `rd` and `is_load` per slot, held in a shift register.

Each cycle the slots shift toward `DEPTH-1`, and the entry in slot `DEPTH-1` retires. Slot 0 is loaded as follows:
- `{1, issue_rd_index_i, issue_is_load_i}` when `issue_valid_i & ~stall_o & ~flush_i`.
- Otherwise a bubble (`valid=0`).

A slot j matches source k when `valid[j] & rd[j]!=0 & rd[j]==rs_k`. The lowest matching j (the youngest) wins.

A winning slot is ready unless `is_load[j] & j < LOAD_LAT`.

Output for source k:
- 0 if `rs_k==0`.
- Otherwise `stage_result_i[j]` of the winning ready slot.
- Otherwise, with no match, `issue_rs_value_i[k]`.

If the winner is not ready, the value is don't-care and that source requests a stall.

`stall_o = issue_valid_i & ~flush_i & (OR of all per-source stall requests)`.

Older matching slots never override a younger non-ready match.

`flush_i` wins over stall: `stall_o=0` and a bubble is inserted.

## Timing
- `issue_rs_fwd_o` and `stall_o` are combinational from the current inputs and the slot state. There is no registered latency.
- Slot state updates on the rising edge of `clk_i`.
- A load-use stall lasts `LOAD_LAT` cycles for an immediate consumer, and fewer if the consumer issues later.
- On reset, all `valid=0`, `rd=0`, `is_load=0`, and `stall_count_o=0`. With no valid slots, `stall_o=0` and `issue_rs_fwd_o` equals the RF values, with source 0 forced to 0.
- Reset asserted mid-stall clears all slots on that edge. `stall_o` drops in the next cycle, and the issuing instruction is not inserted.
- A producer in slot `DEPTH-1` forwards in the same cycle the register file is written, which covers read-during-write.

## Configuration
- `SCOREBOARD_STALL_CNT_EN` defined:
  - `stall_count_o` exists.
  - It increments on every clock where `stall_o=1` and `reset_i=0`.
  - It saturates at `32'hFFFF_FFFF`.
  - It is cleared by reset.
- `SCOREBOARD_STALL_CNT_EN` undefined: the port and the counter are absent. The interface and behaviour are otherwise identical.

## Test plan
Defaults: `DEPTH=3`, `LOAD_LAT=1`, `NUM_SRC=2`.
1. **ALU back-to-back:** issue `rd=5`, non-load. Next cycle issue `rs1=5` with `stage_result_i[0]=0x0000_1234` and RF value `0xAAAA_AAAA` → `fwd[0]=0x0000_1234`, `stall_o=0`.
2. **Load-use:** issue load `rd=7`. Next cycle issue `rs2=7` → `stall_o=1` for exactly 1 cycle. The following cycle, with `stage_result_i[1]=0xDEAD_BEEF` → `fwd[1]=0xDEAD_BEEF`, `stall_o=0`. `stall_count_o` increments by 1.
3. **Priority:** `rd=3` valid in slot 0 (`0x11`) and slot 2 (`0x33`); issue `rs1=rs2=3` → both outputs `0x11`.
4. **x0 handling:** issue `rd=0`, then issue `rs1=0` with RF value `0xFFFF_FFFF` → `fwd[0]=0`, `stall_o=0`. A load to `rd=0` followed by a use of x0 → no stall.
5. **Flush:** issue `rd=4` with `flush_i=1`. Next cycle issue `rs1=4` with RF value `0x44` → `fwd[0]=0x44`. A pending load-use stall asserted together with `flush_i` → `stall_o=0`.
6. **Reset mid-stall:** create the load-use stall of scenario 2, then assert `reset_i` for 1 cycle → all slots invalid, `stall_o=0`, counter 0, and `fwd` equals the RF values.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// Operand-forwarding and load-use interlock for the in-order pipeline.
// Optional stall-cycle counter port is built only when SCOREBOARD_STALL_CNT_EN is defined.
module hazard_scoreboard #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int NUM_SRC    = 2,
  parameter int DEPTH      = 3,
  parameter int LOAD_LAT   = 1
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          issue_valid_i,
  input  logic [REG_ADDR_W-1:0]         issue_rd_index_i,
  input  logic                          issue_is_load_i,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] issue_rs_index_i,
  input  logic [NUM_SRC*XLEN-1:0]       issue_rs_value_i,
  input  logic [DEPTH*XLEN-1:0]         stage_result_i,
  input  logic                          flush_i,
  output logic [NUM_SRC*XLEN-1:0]       issue_rs_fwd_o,
  output logic                          stall_o
`ifdef SCOREBOARD_STALL_CNT_EN
  ,
  output logic [31:0]                   stall_count_o
`endif
);

  logic [DEPTH-1:0]      slot_valid;
  logic [DEPTH-1:0]      slot_is_load;
  logic [REG_ADDR_W-1:0] slot_rd [DEPTH];

  logic [DEPTH-1:0]      match [NUM_SRC];
  logic [NUM_SRC-1:0]    src_stall;
  logic                  insert;

  // A slot matches a source when it holds a live, non-x0 write to that register.
  always_comb begin
    for (int k = 0; k < NUM_SRC; k++) begin
      for (int j = 0; j < DEPTH; j++) begin
        match[k][j] = slot_valid[j] && (slot_rd[j] != '0) &&
                      (slot_rd[j] == issue_rs_index_i[k*REG_ADDR_W +: REG_ADDR_W]);
      end
    end
  end

  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch is inferred.
    issue_rs_fwd_o = issue_rs_value_i;
    src_stall      = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      // Walk oldest to youngest so the youngest match overwrites, ready or not.
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (match[k][j]) begin
          issue_rs_fwd_o[k*XLEN +: XLEN] = stage_result_i[j*XLEN +: XLEN];
          src_stall[k]                   = slot_is_load[j] && (j < LOAD_LAT);
        end
      end
      if (issue_rs_index_i[k*REG_ADDR_W +: REG_ADDR_W] == '0) begin
        issue_rs_fwd_o[k*XLEN +: XLEN] = '0;
      end
    end
  end

  // Flush squashes the issuing instruction, so it can neither stall nor enter slot 0.
  assign stall_o = issue_valid_i && !flush_i && (|src_stall);
  assign insert  = issue_valid_i && !stall_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      slot_valid   <= '0;
      slot_is_load <= '0;
      // NOTE: the rd array is cleared explicitly; a reset on valid alone would leave stale indices.
      for (int j = 0; j < DEPTH; j++) begin
        slot_rd[j] <= '0;
      end
    end else begin
      // NOTE: non-blocking so each slot takes its neighbour's pre-edge value.
      slot_valid   <= {slot_valid[DEPTH-2:0], insert};
      slot_is_load <= {slot_is_load[DEPTH-2:0], insert && issue_is_load_i};
      slot_rd[0]   <= insert ? issue_rd_index_i : '0;
      for (int j = 1; j < DEPTH; j++) begin
        slot_rd[j] <= slot_rd[j-1];
      end
    end
  end

`ifdef SCOREBOARD_STALL_CNT_EN
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stall_count_o <= '0;
    end else if (stall_o && (stall_count_o != 32'hFFFF_FFFF)) begin
      stall_count_o <= stall_count_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: an age-based in-flight model checked every
// cycle plus directed scenarios with literal expectations.
module tb_hazard_scoreboard;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int NS   = 2;
  localparam int D    = 3;
  localparam int LL   = 1;

  logic              clk = 1'b0;
  logic              reset_i;
  logic              issue_valid;
  logic [RW-1:0]     issue_rd;
  logic              issue_is_load;
  logic [NS*RW-1:0]  rs_idx;
  logic [NS*XLEN-1:0] rs_val;
  logic [D*XLEN-1:0] stage;
  logic              flush;
  logic [NS*XLEN-1:0] fwd;
  logic              stall;
`ifdef SCOREBOARD_STALL_CNT_EN
  logic [31:0]       stall_count;
`endif

  int vectors     = 0;
  int miscompares = 0;

  hazard_scoreboard #(
    .XLEN(XLEN), .REG_ADDR_W(RW), .NUM_SRC(NS), .DEPTH(D), .LOAD_LAT(LL)
  ) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .issue_valid_i   (issue_valid),
    .issue_rd_index_i(issue_rd),
    .issue_is_load_i (issue_is_load),
    .issue_rs_index_i(rs_idx),
    .issue_rs_value_i(rs_val),
    .stage_result_i  (stage),
    .flush_i         (flush),
    .issue_rs_fwd_o  (fwd),
    .stall_o         (stall)
`ifdef SCOREBOARD_STALL_CNT_EN
    ,
    .stall_count_o   (stall_count)
`endif
  );

  always #5 clk = ~clk;

  // Model: every accepted instruction remembers the cycle it entered; its age is its slot.
  typedef struct {
    int            tag;
    logic [RW-1:0] rd;
    logic          ld;
  } entry_t;

  entry_t      q[$];
  int          cyc     = 0;
  bit          armed   = 1'b0;
  logic [31:0] exp_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [XLEN-1:0] fwd_src(input int k);
    return fwd[k*XLEN +: XLEN];
  endfunction

  function automatic void model_eval(output logic [NS*XLEN-1:0] m_fwd,
                                     output logic m_stall, output logic [NS-1:0] care);
    logic any_req;
    any_req = 1'b0;
    care    = '1;
    m_fwd   = '0;
    for (int k = 0; k < NS; k++) begin
      logic [RW-1:0]   rs;
      logic [XLEN-1:0] value;
      bit              hit;
      rs    = rs_idx[k*RW +: RW];
      value = rs_val[k*XLEN +: XLEN];
      hit   = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        int age;
        age = cyc - q[i].tag;
        if (!hit && age < D && q[i].rd != 0 && q[i].rd == rs) begin
          hit = 1'b1;
          if (q[i].ld && age < LL) begin
            care[k] = 1'b0;
            any_req = 1'b1;
          end else begin
            value = stage[age*XLEN +: XLEN];
          end
        end
      end
      if (rs == 0) value = '0;
      m_fwd[k*XLEN +: XLEN] = value;
    end
    m_stall = issue_valid && !flush && any_req;
  endfunction

  initial begin
    logic [NS*XLEN-1:0] f;
    logic               s;
    logic [NS-1:0]      c;
    forever begin
      @(posedge clk);
      model_eval(f, s, c);
      cyc++;
      if (reset_i) begin
        q.delete();
        armed   = 1'b1;
        exp_cnt = '0;
      end else begin
        if (s && exp_cnt != 32'hFFFF_FFFF) exp_cnt++;
        if (issue_valid && !s && !flush) q.push_back('{cyc, issue_rd, issue_is_load});
        while (q.size() > 0 && cyc - q[0].tag >= D) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [NS*XLEN-1:0] f;
    logic               s;
    logic [NS-1:0]      c;
    forever begin
      @(negedge clk);
      if (armed) begin
        model_eval(f, s, c);
        check("model_stall", {31'd0, stall}, {31'd0, s});
        for (int k = 0; k < NS; k++) begin
          if (c[k]) check($sformatf("model_fwd%0d", k), fwd_src(k), f[k*XLEN +: XLEN]);
        end
`ifdef SCOREBOARD_STALL_CNT_EN
        check("model_count", stall_count, exp_cnt);
`endif
      end
    end
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [RW-1:0] rd, input logic ld,
                           input logic [RW-1:0] r0, input logic [RW-1:0] r1, input logic fl);
    issue_valid   = v;
    issue_rd      = rd;
    issue_is_load = ld;
    rs_idx        = {r1, r0};
    flush         = fl;
  endtask

  initial begin
    reset_i = 1'b1;
    stage   = '0;
    rs_val  = '0;
    set_issue(0, 0, 0, 0, 0, 0);
    next();
    next();

    // Reset state: nothing in flight, RF values pass with x0 forced to zero.
    reset_i = 1'b0;
    set_issue(0, 0, 0, 0, 9, 0);
    rs_val = {32'h2222_2222, 32'h1111_1111};
    #1;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_fwd0", fwd_src(0), 32'd0);
    check("rst_fwd1", fwd_src(1), 32'h2222_2222);

    // ALU back-to-back.
    next(); set_issue(1, 5, 0, 0, 0, 0);
    next(); set_issue(1, 0, 0, 5, 0, 0);
    stage[31:0] = 32'h0000_1234; rs_val[31:0] = 32'hAAAA_AAAA;
    #1;
    check("alu_fwd0", fwd_src(0), 32'h0000_1234);
    check("alu_stall", {31'd0, stall}, 32'd0);

    // Load-use: one stall cycle, then forward from slot 1.
    next(); set_issue(1, 7, 1, 0, 0, 0);
    next(); set_issue(1, 0, 0, 0, 7, 0);
    #1;
    check("ldu_stall", {31'd0, stall}, 32'd1);
    next(); stage[63:32] = 32'hDEAD_BEEF;
    #1;
    check("ldu_release", {31'd0, stall}, 32'd0);
    check("ldu_fwd1", fwd_src(1), 32'hDEAD_BEEF);
`ifdef SCOREBOARD_STALL_CNT_EN
    check("ldu_count", stall_count, 32'd1);
`endif

    // Priority: youngest of two rd=3 producers wins.
    next(); set_issue(1, 3, 0, 0, 0, 0);
    next(); set_issue(1, 9, 0, 0, 0, 0);
    next(); set_issue(1, 3, 0, 0, 0, 0);
    next(); set_issue(0, 0, 0, 3, 3, 0);
    stage = {32'h33, 32'h22, 32'h11};
    #1;
    check("prio_fwd0", fwd_src(0), 32'h11);
    check("prio_fwd1", fwd_src(1), 32'h11);

    // x0: never forwarded, never stalls.
    next(); set_issue(1, 0, 0, 0, 0, 0);
    next(); set_issue(1, 0, 0, 0, 0, 0); rs_val[31:0] = 32'hFFFF_FFFF;
    #1;
    check("x0_fwd0", fwd_src(0), 32'd0);
    check("x0_stall", {31'd0, stall}, 32'd0);
    next(); set_issue(1, 0, 1, 0, 0, 0);
    next(); set_issue(1, 0, 0, 0, 0, 0);
    #1;
    check("x0_load_stall", {31'd0, stall}, 32'd0);

    // Flush: squashed producer is invisible; flush overrides a pending stall.
    next(); set_issue(1, 4, 0, 0, 0, 1);
    next(); set_issue(1, 0, 0, 4, 0, 0); rs_val[31:0] = 32'h44;
    #1;
    check("flush_fwd0", fwd_src(0), 32'h44);
    next(); set_issue(1, 6, 1, 0, 0, 0);
    next(); set_issue(1, 0, 0, 6, 0, 1);
    #1;
    check("flush_stall", {31'd0, stall}, 32'd0);
    next(); set_issue(1, 0, 0, 6, 0, 0); stage[63:32] = 32'h66;
    #1;
    check("flush_after_stall", {31'd0, stall}, 32'd0);
    check("flush_after_fwd0", fwd_src(0), 32'h66);

    // Writeback slot still forwards; one cycle later the producer has retired.
    next(); set_issue(1, 10, 0, 0, 0, 0);
    next(); set_issue(0, 0, 0, 0, 0, 0);
    next();
    next(); set_issue(0, 0, 0, 10, 0, 0);
    stage[95:64] = 32'h55; rs_val[31:0] = 32'h99;
    #1;
    check("wb_fwd0", fwd_src(0), 32'h55);
    next();
    #1;
    check("retired_fwd0", fwd_src(0), 32'h99);

    // Reset mid-stall clears the slots and drops the stalled instruction.
    next(); set_issue(1, 7, 1, 0, 0, 0);
    next(); set_issue(1, 12, 0, 2, 7, 0);
    rs_val = {32'h7777, 32'h2020};
    #1;
    check("rms_stall", {31'd0, stall}, 32'd1);
    reset_i = 1'b1;
    next();
    reset_i = 1'b0;
    set_issue(0, 0, 0, 2, 7, 0);
    #1;
    check("rms_stall_after", {31'd0, stall}, 32'd0);
    check("rms_fwd0", fwd_src(0), 32'h2020);
    check("rms_fwd1", fwd_src(1), 32'h7777);
`ifdef SCOREBOARD_STALL_CNT_EN
    check("rms_count", stall_count, 32'd0);
`endif
    next(); set_issue(0, 0, 0, 12, 0, 0); rs_val[31:0] = 32'h1212;
    #1;
    check("rms_not_inserted", fwd_src(0), 32'h1212);

    next();
    next();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
